// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and op classification for the handshaked sequential ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'b0000,
        OpNeg  = 4'b0001,
        OpAnd  = 4'b0010,
        OpXor  = 4'b0011,
        OpSllI = 4'b0100,
        OpSrlI = 4'b0101,
        OpSraI = 4'b0110,
        OpSub  = 4'b0111,
        OpMul  = 4'b1000,
        OpDivu = 4'b1001,
        OpRemu = 4'b1010,
        OpRsvB = 4'b1011,
        OpSllR = 4'b1100,
        OpSrlR = 4'b1101,
        OpSraR = 4'b1110,
        OpRsvF = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StIter = 2'b01,
        StDone = 2'b10
    } alu_state_e;

    function automatic logic alu_is_iter(input logic [3:0] op);
        return (op == OpMul) || (op == OpDivu) || (op == OpRemu);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide/remainder, one step per cycle.
// done_o flags the final step; result_o then carries that step's outcome.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned SHW = $clog2(WIDTH);

    // acc: product or partial remainder; opa: multiplicand or dividend/quotient;
    // opb: multiplier or divisor.
    logic [WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
    logic [SHW-1:0]   cnt_q;
    logic             run_q, mul_q, rem_q;
    logic [WIDTH:0]   rem_sh;

    always_comb begin
        rem_sh = {acc_q, opa_q[WIDTH-1]};
        opb_d  = opb_q;
        if (mul_q) begin
            acc_d = opb_q[0] ? acc_q + opa_q : acc_q;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
        end else if (rem_sh >= {1'b0, opb_q}) begin
            acc_d = WIDTH'(rem_sh - {1'b0, opb_q});
            opa_d = {opa_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = rem_sh[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], 1'b0};
        end
    end

    assign done_o   = run_q && (cnt_q == '0);
    assign result_o = (mul_q || rem_q) ? acc_d : opa_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            mul_q <= 1'b0;
            rem_q <= 1'b0;
        end else if (start_i) begin
            acc_q <= '0;
            opa_q <= a_i;
            opb_q <= b_i;
            cnt_q <= SHW'(WIDTH - 1);
            run_q <= 1'b1;
            mul_q <= (op_i == OpMul);
            rem_q <= (op_i == OpRemu);
        end else if (run_q) begin
            acc_q <= acc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            cnt_q <= cnt_q - SHW'(1);
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle datapath plus iterative mul/div, registered result stage.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             busy_o
);

    alu_state_e        state_q;
    logic [WIDTH-1:0]  result_q;
    logic              carry_q, zero_q;

    logic              accept, start_iter, md_done;
    logic [WIDTH-1:0]  md_result;

    logic [WIDTH:0]    sum_ext, diff_ext;
    logic [WIDTH-1:0]  alu_res, sra_res;
    logic signed [WIDTH-1:0] a_s;
    logic              alu_carry, reg_oob;
    logic [SHW-1:0]    sh_amt;

    assign in_ready_o  = (state_q == StIdle) || ((state_q == StDone) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign start_iter  = accept && alu_is_iter(op_i);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q == StIter);
    assign result_o    = result_q;
    assign carry_o     = carry_q;
    assign zero_o      = zero_q;

    always_comb begin
        sum_ext   = {1'b0, a_i} + {1'b0, b_i};
        diff_ext  = {1'b0, a_i} - {1'b0, b_i};
        // op[3] selects the register-sourced shift variants
        sh_amt    = op_i[3] ? b_i[SHW-1:0] : shamt_i;
        reg_oob   = op_i[3] && (|b_i[WIDTH-1:SHW]);
        a_s       = a_i;
        sra_res   = a_s >>> sh_amt;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (alu_op_e'(op_i))
            OpAdd: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            OpNeg:          alu_res = ~b_i + WIDTH'(1);
            OpAnd:          alu_res = a_i & b_i;
            OpXor:          alu_res = a_i ^ b_i;
            OpSllI, OpSllR: alu_res = reg_oob ? '0 : a_i << sh_amt;
            OpSrlI, OpSrlR: alu_res = reg_oob ? '0 : a_i >> sh_amt;
            OpSraI, OpSraR: alu_res = reg_oob ? {WIDTH{a_i[WIDTH-1]}} : sra_res;
            OpSub: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = ~diff_ext[WIDTH];
            end
            default: ;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_iter),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .done_o  (md_done),
        .result_o(md_result)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        if (alu_is_iter(op_i)) begin
                            state_q <= StIter;
                        end else begin
                            result_q <= alu_res;
                            carry_q  <= alu_carry;
                            zero_q   <= (alu_res == '0);
                            state_q  <= StDone;
                        end
                    end else if (state_q == StDone && out_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                StIter: begin
                    if (md_done) begin
                        result_q <= md_result;
                        carry_q  <= 1'b0;
                        zero_q   <= (md_result == '0);
                        state_q  <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scenario bench for alu_seq: expected results queued at issue, popped when the DUT presents them.
module tb_alu_seq;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [4:0]   shamt = '0;
    logic         in_ready, out_valid, carry, zero, busy;
    logic [W-1:0] result;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    logic [3:0] single_ops [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                   4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH(W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .shamt_i    (shamt),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .carry_o    (carry),
        .zero_o     (zero),
        .busy_o     (busy)
    );

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [4:0] s);
        exp_t e;
        logic [W:0] wide;
        logic signed [W-1:0] xs;
        e.res = '0;
        e.c = 1'b0;
        xs = x;
        case (o)
            4'h0: begin wide = {1'b0, x} + {1'b0, y}; e.res = wide[W-1:0]; e.c = wide[W]; end
            4'h1: e.res = 32'd0 - y;
            4'h2: e.res = x & y;
            4'h3: e.res = x ^ y;
            4'h4: e.res = x << s;
            4'h5: e.res = x >> s;
            4'h6: e.res = xs >>> s;
            4'h7: begin e.res = x - y; e.c = (x >= y); end
            4'h8: e.res = x * y;
            4'h9: e.res = (y == 0) ? '1 : x / y;
            4'hA: e.res = (y == 0) ? x : x % y;
            4'hC: e.res = (y >= W) ? '0 : x << y;
            4'hD: e.res = (y >= W) ? '0 : x >> y;
            4'hE: begin
                e.res = x;
                for (int k = 0; k < W && k < y; k++) e.res = {x[W-1], e.res[W-1:1]};
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic expect_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [4:0] s);
        exp_q.push_back(model(o, x, y, s));
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [4:0] s);
        op = o; a = x; b = y; shamt = s; in_valid = 1'b1;
        expect_op(o, x, y, s);
    endtask

    // Bounded wait for out_valid, sampled on falling edges; drops in_valid after the accept edge.
    task automatic wait_out(input int max, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
        end while (out_valid !== 1'b1 && cyc < max);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({result, carry, zero, out_valid, busy} !== '0)
            $display("FAIL reset_outputs: got res=%h c=%b z=%b v=%b busy=%b want all 0",
                     result, carry, zero, out_valid, busy);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_add_carry();
        exp_t e;
        int cyc;
        issue(4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
        wait_out(4, cyc);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc != 1 || out_valid !== 1'b1)
            $display("FAIL add_latency: got %0d cycles valid=%b want 1 cycle", cyc, out_valid);
        else n_pass++;
        n_checks++;
        if ({result, carry, zero} !== {e.res, e.c, 1'b1})
            $display("FAIL add_carry: got res=%h c=%b z=%b want res=%h c=%b z=1",
                     result, carry, zero, e.res, e.c);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        issue(4'h7, 32'd5, 32'd7, 5'd0);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if ({out_valid, result, carry} !== {1'b1, e.res, e.c})
            $display("FAIL b2b_sub: got v=%b res=%h c=%b want v=1 res=%h c=%b",
                     out_valid, result, carry, e.res, e.c);
        else n_pass++;
        issue(4'hE, 32'h8000_0000, 32'd40, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if ({out_valid, result, carry} !== {1'b1, e.res, e.c})
            $display("FAIL b2b_sra_reg: got v=%b res=%h c=%b want v=1 res=%h c=%b",
                     out_valid, result, carry, e.res, e.c);
        else n_pass++;
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] y;
            y = (i % 3 == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            issue(single_ops[$urandom_range(0, 12)], W'($urandom), y, 5'($urandom));
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({out_valid, result, carry, zero} !== {1'b1, e.res, e.c, e.res == '0})
                $display("FAIL b2b_random[%0d]: op=%h got v=%b res=%h c=%b z=%b want res=%h c=%b",
                         i, op, out_valid, result, carry, zero, e.res, e.c);
            else n_pass++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mul();
        exp_t e;
        int cyc;
        logic bad;
        @(negedge clk);
        issue(4'h8, 32'h0001_0003, 32'h0002_0005, 5'd0);
        cyc = 0;
        bad = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                in_valid = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
            end
            if (out_valid !== 1'b1 && (busy !== 1'b1 || in_ready !== 1'b0)) bad = 1'b1;
        end while (out_valid !== 1'b1 && cyc < 40);
        e = exp_q.pop_front();
        n_checks++;
        if (bad) $display("FAIL mul_busy: got busy/in_ready wrong during ITER want busy=1 in_ready=0");
        else n_pass++;
        n_checks++;
        if (cyc != 33 || busy !== 1'b0)
            $display("FAIL mul_latency: got %0d cycles busy=%b want 33 busy=0", cyc, busy);
        else n_pass++;
        n_checks++;
        if ({out_valid, result, carry} !== {1'b1, e.res, e.c})
            $display("FAIL mul_result: got v=%b res=%h c=%b want res=%h c=%b",
                     out_valid, result, carry, e.res, e.c);
        else n_pass++;
    endtask

    task automatic test_div();
        exp_t e;
        int cyc;
        logic [3:0]   ops [4] = '{4'h9, 4'hA, 4'h9, 4'hA};
        logic [W-1:0] xs  [4] = '{32'd100, 32'd100, 32'd9, 32'd9};
        logic [W-1:0] ys  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], xs[i], ys[i], 5'd0);
            wait_out(40, cyc);
            e = exp_q.pop_front();
            n_checks++;
            if (cyc != 33 || {out_valid, result, carry, zero} !== {1'b1, e.res, 1'b0, e.res == '0})
                $display("FAIL div[%0d]: got %0d cycles v=%b res=%h c=%b z=%b want 33 res=%h",
                         i, cyc, out_valid, result, carry, zero, e.res);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic bad;
        @(negedge clk);
        out_ready = 1'b0;
        issue(4'h3, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0);
        @(negedge clk);
        op = 4'h0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || result !== exp_q[0].res || in_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (bad) $display("FAIL stall_hold: got result/valid/in_ready unstable want %h held", exp_q[0].res);
        else n_pass++;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL stall_release: got in_ready=%b want 1", in_ready);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if ({out_valid, result, carry, zero} !== {1'b1, e.res, e.c, 1'b0})
            $display("FAIL stall_xor: got v=%b res=%h want res=%h", out_valid, result, e.res);
        else n_pass++;
        expect_op(4'h0, 32'd1, 32'd1, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if ({out_valid, result, carry} !== {1'b1, e.res, e.c})
            $display("FAIL done_accept: got v=%b res=%h c=%b want res=%h", out_valid, result, carry, e.res);
        else n_pass++;
    endtask

    task automatic test_reset_mid_iter();
        exp_t e;
        int cyc;
        @(negedge clk);
        issue(4'h9, 32'd1000, 32'd3, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL iter_busy: got busy=%b want 1", busy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({result, carry, zero, out_valid, busy} !== '0)
            $display("FAIL async_reset: got res=%h c=%b z=%b v=%b busy=%b want all 0",
                     result, carry, zero, out_valid, busy);
        else n_pass++;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(4'h0, 32'd2, 32'd3, 5'd0);
        wait_out(4, cyc);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc != 1 || {out_valid, result, carry} !== {1'b1, e.res, e.c})
            $display("FAIL post_reset_add: got %0d cycles v=%b res=%h want 1 cycle res=%h",
                     cyc, out_valid, result, e.res);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_back_to_back();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_iter();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle datapath ALU. Adds a registered result stage with valid/ready flow control, register-sourced shift amounts, subtraction, and iterative unsigned multiply/divide/remainder that run over WIDTH cycles. Sits between the register-file read stage and writeback; the control unit issues one operation per accepted handshake and stalls on `in_ready` low.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥ 4 and a power of 2.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; not overridden).

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  block accepts operation this cycle
- `op`  in  4  operation code (see Operation)
- `a`  in  WIDTH  operand A (unsigned, or signed where stated)
- `b`  in  WIDTH  operand B
- `shamt`  in  SHW  immediate shift amount
- `out_valid`  out  1  result registered and held
- `out_ready`  in  1  consumer takes result
- `result`  out  WIDTH  operation result
- `carry`  out  1  carry/no-borrow flag
- `zero`  out  1  result == 0
- `busy`  out  1  iterative operation in progress

## Operation
- Op codes: 0000 ADD a+b; 0001 NEG ~b+1; 0010 AND; 0011 XOR; 0100/0101/0110 SLL/SRL/SRA a by `shamt`; 0111 SUB a−b; 1100/1101/1110 SLL/SRL/SRA a by `b`; 1000 MUL (low WIDTH bits of a×b); 1001 DIVU a/b; 1010 REMU a%b; 1011, 1111 reserved → result 0, carry 0.
- Register-sourced shifts use full `b`: b ≥ WIDTH gives 0 for SLL/SRL and WIDTH copies of a[WIDTH-1] for SRA.
- `carry`: ADD = carry-out of a+b; SUB = 1 when a ≥ b unsigned (no borrow); all other ops 0.
- `zero` computed from the registered result; valid whenever `out_valid`.
- DIVU/REMU with b = 0: quotient all ones, remainder = a; still takes the full iteration count.
- Operands and op latched at acceptance; input changes afterwards have no effect.
- FSM states: IDLE, ITER, DONE.
  - IDLE: `in_ready`=1. Accept of a single-cycle op → DONE; of MUL/DIVU/REMU → ITER, counter loaded with WIDTH−1.
  - ITER: one shift-add (MUL) or restoring subtract-shift (DIVU/REMU) step per cycle; counter 0 on a step → DONE. `busy`=1, `in_ready`=0.
  - DONE: `out_valid`=1; result/carry/zero held stable until `out_ready`. With `out_ready`=1: `in_ready`=1; a simultaneous new accept goes directly to DONE (single-cycle op) or ITER (iterative op); otherwise → IDLE.

## Timing
- Reset (asynchronous assertion, synchronous release): state IDLE, `result`=0, `carry`=0, `zero`=0, `out_valid`=0, `busy`=0, `in_ready`=1 once released.
- Reset mid-ITER or in DONE aborts the operation; pending result is lost.
- Single-cycle ops: `out_valid` rises on the edge after acceptance (latency 1); sustained throughput 1 op/cycle with `out_ready` held high.
- MUL/DIVU/REMU: `out_valid` rises WIDTH+1 edges after acceptance (33 for WIDTH=32).
- Transfer occurs on a rising edge with `out_valid`&&`out_ready`; accept on `in_valid`&&`in_ready`.
- `in_ready` is combinational from state and `out_ready` only; no combinational path from `in_valid` to any output.

## Structure
- Package `alu_pkg`: op-code localparams/enum, FSM state enum, and the `alu_is_iter(op)` function.
- Sub-module `alu_muldiv_iter`: holds the accumulator/remainder, multiplicand/divisor registers and step counter; start/done interface; parametrised by WIDTH. The top level holds the FSM, the combinational single-cycle datapath, and the output register.

## Test plan
- Reset released, ADD a=0xFFFFFFFF b=0x00000001 → next cycle result 0x00000000, carry 1, zero 1, out_valid 1.
- Back-to-back with out_ready=1: SUB 5−7, then SRA a=0x80000000 by b=40 → results 0xFFFFFFFE (carry 0), then 0xFFFFFFFF, on consecutive cycles.
- MUL a=0x00010003 b=0x00020005 → busy for 32 cycles, result 0x000B000F at cycle 33; in_ready low throughout.
- DIVU 100/7 → 14, REMU 100/7 → 2; DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- out_ready held low 5 cycles after XOR 0xF0F0F0F0^0xFFFF0000 → result 0x0F0FF0F0 stable, in_ready 0 until released.
- rst_n asserted at ITER cycle 10 of DIVU → all outputs 0 immediately; after release a new ADD 2+3 returns 5 with latency 1.
